// File: rtl/mmio_responder.sv
// Memory-mapped responder: cycle counter, compare/match flag and scratch words,
// answering word-addressed loads/stores with a fixed response latency.
module mmio_responder #(
  parameter logic [29:0] BASE_WORD = 30'h0000_8000,
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [29:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        irq
);

  localparam int unsigned IDX_W   = $clog2(NUM_REGS);
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_CYC = 0;
  localparam int unsigned IDX_CMP = 1;
  localparam int unsigned IDX_STS = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        cycle_q;
  logic [31:0]        cmp_q;
  logic               status_q;
  logic [31:0]        scratch_q [3:NUM_REGS-1];
  logic [31:0]        hold_rdata_q;
  logic               hold_err_q;
  logic               req_ready_q;
  logic               resp_valid_q;
  logic [31:0]        resp_rdata_q;
  logic               resp_err_q;

  logic [29:0]        offset_c;
  logic               hit_c;
  logic [IDX_W-1:0]   idx_c;
  logic               accept_c;
  logic               wr_c;
  logic               match_c;
  logic [31:0]        rd_data_c;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Window decode and read mux
  always_comb begin
    offset_c  = req_addr - BASE_WORD;
    hit_c     = (req_addr >= BASE_WORD) && (offset_c < 30'(NUM_REGS));
    idx_c     = offset_c[IDX_W-1:0];
    accept_c  = (state_q == S_IDLE) && req_valid;
    wr_c      = accept_c && req_write && hit_c;
    match_c   = (cycle_q == cmp_q);
    rd_data_c = 32'h0;
    if (idx_c == IDX_W'(IDX_CYC)) rd_data_c = cycle_q;
    if (idx_c == IDX_W'(IDX_CMP)) rd_data_c = cmp_q;
    if (idx_c == IDX_W'(IDX_STS)) rd_data_c = {31'h0, status_q};
    for (int i = 3; i < int'(NUM_REGS); i++) begin
      if (idx_c == IDX_W'(i)) rd_data_c = scratch_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cycle_q      <= 32'h0;
      cmp_q        <= 32'hFFFF_FFFF;
      status_q     <= 1'b0;
      for (int i = 3; i < int'(NUM_REGS); i++) scratch_q[i] <= 32'h0;
      hold_rdata_q <= 32'h0;
      hold_err_q   <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;

      // Match set takes priority over a simultaneous write-1-to-clear
      if (match_c) begin
        status_q <= 1'b1;
      end else if (wr_c && idx_c == IDX_W'(IDX_STS) && req_byteen[0] && req_wdata[0]) begin
        status_q <= 1'b0;
      end

      if (wr_c && idx_c == IDX_W'(IDX_CMP)) begin
        cmp_q <= merge_bytes(cmp_q, req_wdata, req_byteen);
      end
      for (int i = 3; i < int'(NUM_REGS); i++) begin
        if (wr_c && idx_c == IDX_W'(i)) begin
          scratch_q[i] <= merge_bytes(scratch_q[i], req_wdata, req_byteen);
        end
      end

      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            hold_rdata_q <= (hit_c && !req_write) ? rd_data_c : 32'h0;
            hold_err_q   <= !hit_c;
            cnt_q        <= CNT_W'(LATENCY - 1);
            state_q      <= S_WAIT;
            req_ready_q  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= hold_rdata_q;
            resp_err_q   <= hold_err_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign irq        = status_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: latency, byte enables, window misses,
// compare/irq behaviour and reset during an outstanding request.
module tb_mmio_responder;

  localparam logic [29:0] BASE    = 30'h0000_8000;
  localparam int unsigned NREGS   = 8;
  localparam int unsigned LAT     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [29:0] req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        irq;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] m_cyc = 32'h0;
  logic [31:0] acc_cyc;
  logic [31:0] rd;
  logic        er;
  logic [31:0] exp_cmp;

  mmio_responder #(.BASE_WORD(BASE), .NUM_REGS(NREGS), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_byteen(req_byteen), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference cycle count: value CYCLE holds between edges
  always @(posedge clk) begin
    if (reset) m_cyc <= 32'h0;
    else       m_cyc <= m_cyc + 32'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic xfer(input logic wr, input logic [29:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] rdata, output logic err);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_req", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_byteen = be; req_wdata = wd;
    acc_cyc = m_cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ready_low_after_accept", 32'(req_ready), 32'h0);
    chk("no_early_resp", 32'(resp_valid), 32'h0);
    for (int i = 1; i < int'(LAT); i++) begin
      @(posedge clk); #1;
      chk("wait_no_resp", 32'(resp_valid), 32'h0);
      chk("wait_ready_low", 32'(req_ready), 32'h0);
    end
    @(posedge clk); #1;
    chk("resp_at_latency", 32'(resp_valid), 32'h1);
    chk("resp_ready_low", 32'(req_ready), 32'h0);
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clk); #1;
    chk("resp_one_cycle", 32'(resp_valid), 32'h0);
    chk("rdata_zero_idle", resp_rdata, 32'h0);
    chk("ready_back", 32'(req_ready), 32'h1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_byteen = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk); reset = 1'b0;

    // Scratch load after reset, reset values of CMP/STATUS
    xfer(1'b0, BASE + 30'd3, 4'h0, 32'h0, rd, er);
    chk("ld3_rdata", rd, 32'h0);
    chk("ld3_err", 32'(er), 32'h0);
    xfer(1'b0, BASE + 30'd1, 4'h0, 32'h0, rd, er);
    chk("cmp_reset", rd, 32'hFFFF_FFFF);
    xfer(1'b0, BASE + 30'd2, 4'h0, 32'h0, rd, er);
    chk("status_reset", rd, 32'h0);

    // Byte-enabled store
    xfer(1'b1, BASE + 30'd4, 4'b0101, 32'hAABB_CCDD, rd, er);
    chk("st4_rdata", rd, 32'h0);
    chk("st4_err", 32'(er), 32'h0);
    xfer(1'b0, BASE + 30'd4, 4'h0, 32'h0, rd, er);
    chk("ld4_merged", rd, 32'h00BB_00DD);
    xfer(1'b1, BASE + 30'd7, 4'hF, 32'h1234_5678, rd, er);
    xfer(1'b0, BASE + 30'd7, 4'h0, 32'h0, rd, er);
    chk("ld7_full", rd, 32'h1234_5678);

    // Window misses
    xfer(1'b0, BASE + 30'(NREGS), 4'h0, 32'h0, rd, er);
    chk("miss_hi_err", 32'(er), 32'h1);
    chk("miss_hi_rdata", rd, 32'h0);
    xfer(1'b0, BASE - 30'd1, 4'h0, 32'h0, rd, er);
    chk("miss_lo_err", 32'(er), 32'h1);
    xfer(1'b1, BASE + 30'(NREGS), 4'hF, 32'hDEAD_BEEF, rd, er);
    chk("miss_st_err", 32'(er), 32'h1);
    xfer(1'b0, BASE + 30'd4, 4'h0, 32'h0, rd, er);
    chk("ld4_after_miss", rd, 32'h00BB_00DD);

    // CYCLE read returns pre-increment value; writes ignored without error
    xfer(1'b0, BASE, 4'h0, 32'h0, rd, er);
    chk("cycle_read", rd, acc_cyc);
    xfer(1'b1, BASE, 4'hF, 32'h0, rd, er);
    chk("cycle_wr_noerr", 32'(er), 32'h0);
    xfer(1'b0, BASE, 4'h0, 32'h0, rd, er);
    chk("cycle_after_wr", rd, acc_cyc);

    // Compare match sets sticky irq
    exp_cmp = m_cyc + 32'd40;
    xfer(1'b1, BASE + 30'd1, 4'hF, exp_cmp, rd, er);
    for (int g = 0; g < 100 && m_cyc != exp_cmp; g++) @(negedge clk);
    chk("irq_before_match", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_at_match", 32'(irq), 32'h1);
    repeat (5) @(negedge clk);
    chk("irq_sticky", 32'(irq), 32'h1);
    xfer(1'b0, BASE + 30'd2, 4'h0, 32'h0, rd, er);
    chk("status_set", rd, 32'h1);
    xfer(1'b1, BASE + 30'd2, 4'h0, 32'h1, rd, er);
    chk("w1c_be0_noclear", 32'(irq), 32'h1);
    xfer(1'b1, BASE + 30'd2, 4'h1, 32'h1, rd, er);
    chk("w1c_clears", 32'(irq), 32'h0);

    // W1C accepted on the same edge as a match: set wins
    exp_cmp = m_cyc + 32'd30;
    xfer(1'b1, BASE + 30'd1, 4'hF, exp_cmp, rd, er);
    for (int g = 0; g < 100 && m_cyc != exp_cmp - 32'd1; g++) @(negedge clk);
    chk("irq_pre_coincide", 32'(irq), 32'h0);
    xfer(1'b1, BASE + 30'd2, 4'h1, 32'h1, rd, er);
    chk("w1c_vs_set", 32'(irq), 32'h1);

    // Reset while a response is pending
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = BASE + 30'd4; req_byteen = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_entered", 32'(req_ready), 32'h0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rstwait_ready", 32'(req_ready), 32'h1);
    chk("rstwait_no_resp", 32'(resp_valid), 32'h0);
    chk("rstwait_irq", 32'(irq), 32'h0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rstwait_dropped", 32'(resp_valid), 32'h0);
    end
    xfer(1'b0, BASE + 30'd1, 4'h0, 32'h0, rd, er);
    chk("rst_cmp", rd, 32'hFFFF_FFFF);
    xfer(1'b0, BASE + 30'd4, 4'h0, 32'h0, rd, er);
    chk("rst_scratch4", rd, 32'h0);
    xfer(1'b0, BASE + 30'd7, 4'h0, 32'h0, rd, er);
    chk("rst_scratch7", rd, 32'h0);
    xfer(1'b0, BASE, 4'h0, 32'h0, rd, er);
    chk("rst_cycle", rd, acc_cyc);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
